// File: rtl/fpu_mul_norm_round.sv
// rtl/fpu_mul_norm_round.sv - FP32 multiplier normalise/round/pack, two-stage pipeline
module fpu_mul_norm_round (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_sign,
  input  logic [9:0]  i_exp_sum,
  input  logic [47:0] i_mant_prod,
  input  logic        i_is_nan,
  input  logic        i_is_inf,
  input  logic        i_is_zero,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_inexact
);

  logic               v1, v2;
  logic               s1_load, s2_load;

  logic signed [10:0] s1_e;
  logic signed [10:0] s1_dist;
  logic [47:0]        s1_norm;
  logic [5:0]         s1_shamt;
  logic [47:0]        s1_n;
  logic               s1_sticky;
  logic               s1_tiny;

  logic               r1_sign;
  logic [9:0]         r1_exp;
  logic [47:0]        r1_n;
  logic               r1_sticky;
  logic               r1_tiny;
  logic               r1_nan, r1_inf, r1_zero;

  logic [23:0]        s2_m;
  logic               s2_g, s2_s, s2_rnd;
  logic [24:0]        s2_mr;
  logic [9:0]         s2_e;
  logic [22:0]        s2_frac;
  logic               s2_ovf, s2_inx;
  logic [31:0]        s2_res;

  assign s2_load = !v2 | i_ready;
  assign s1_load = !v1 | s2_load;
  assign o_ready = s1_load;
  assign o_valid = v2;

  // Normalise to bit 47, then denormalise tiny results with a saturating right shift.
  always_comb begin
    s1_norm   = i_mant_prod[47] ? i_mant_prod : {i_mant_prod[46:0], 1'b0};
    s1_e      = $signed({i_exp_sum[9], i_exp_sum}) + (i_mant_prod[47] ? 11'sd1 : 11'sd0);
    s1_tiny   = (s1_e <= 11'sd0);
    s1_dist   = 11'sd1 - s1_e;
    s1_shamt  = 6'd0;
    if (s1_tiny) begin
      s1_shamt = (s1_dist > 11'sd48) ? 6'd48 : s1_dist[5:0];
    end
    s1_n      = s1_norm >> s1_shamt;
    s1_sticky = |(s1_norm & ~({48{1'b1}} << s1_shamt));
  end

  // Stage 1 register: loads whenever it is empty or stage 2 is draining it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1        <= 1'b0;
      r1_sign   <= 1'b0;
      r1_exp    <= '0;
      r1_n      <= '0;
      r1_sticky <= 1'b0;
      r1_tiny   <= 1'b0;
      r1_nan    <= 1'b0;
      r1_inf    <= 1'b0;
      r1_zero   <= 1'b0;
    end else if (s1_load) begin
      v1 <= i_valid;
      if (i_valid) begin
        r1_sign   <= i_sign;
        r1_exp    <= s1_tiny ? 10'd0 : s1_e[9:0];
        r1_n      <= s1_n;
        r1_sticky <= s1_sticky;
        r1_tiny   <= s1_tiny;
        r1_nan    <= i_is_nan;
        r1_inf    <= i_is_inf;
        r1_zero   <= i_is_zero;
      end
    end
  end

  // Round to nearest even, handle mantissa carry, overflow and specials, then pack.
  always_comb begin
    s2_m    = r1_n[47:24];
    s2_g    = r1_n[23];
    s2_s    = (|r1_n[22:0]) | r1_sticky;
    s2_rnd  = s2_g & (s2_s | s2_m[0]);
    s2_mr   = {1'b0, s2_m} + {24'd0, s2_rnd};
    s2_inx  = s2_g | s2_s;
    s2_e    = r1_exp;
    s2_frac = s2_mr[22:0];
    if (s2_mr[24]) begin
      s2_e    = r1_exp + 10'd1;
      s2_frac = 23'd0;
    end
    if (r1_tiny) begin
      // A tiny value that rounds up into bit 23 becomes the smallest normal.
      s2_e = s2_mr[23] ? 10'd1 : 10'd0;
    end
    s2_ovf = !r1_tiny && (s2_e >= 10'd255);
    s2_res = {r1_sign, s2_e[7:0], s2_frac};
    if (s2_ovf) begin
      s2_res = {r1_sign, 8'hFF, 23'd0};
    end
  end

  // Stage 2 / output holding register: only updated when the output is free or consumed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v2          <= 1'b0;
      o_result    <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_inexact   <= 1'b0;
    end else if (s2_load) begin
      v2 <= v1;
      if (v1) begin
        if (r1_nan) begin
          o_result    <= 32'h7FC00000;
          o_overflow  <= 1'b0;
          o_underflow <= 1'b0;
          o_inexact   <= 1'b0;
        end else if (r1_inf) begin
          o_result    <= {r1_sign, 8'hFF, 23'd0};
          o_overflow  <= 1'b0;
          o_underflow <= 1'b0;
          o_inexact   <= 1'b0;
        end else if (r1_zero) begin
          o_result    <= {r1_sign, 31'd0};
          o_overflow  <= 1'b0;
          o_underflow <= 1'b0;
          o_inexact   <= 1'b0;
        end else begin
          o_result    <= s2_res;
          o_overflow  <= s2_ovf;
          o_underflow <= r1_tiny & (s2_inx | s2_ovf);
          o_inexact   <= s2_inx | s2_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_mul_norm_round.sv
// tb/tb_fpu_mul_norm_round.sv - self-checking bench for fpu_mul_norm_round
module tb_fpu_mul_norm_round;

  typedef struct packed {
    logic        sign;
    logic [9:0]  es;
    logic [47:0] prod;
    logic        nan;
    logic        inf;
    logic        zero;
  } in_t;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        un;
    logic        ix;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t out;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, i_sign, i_is_nan, i_is_inf, i_is_zero;
  logic [9:0]  i_exp_sum;
  logic [47:0] i_mant_prod;
  logic        o_valid, i_ready;
  logic [31:0] o_result;
  logic        o_overflow, o_underflow, o_inexact;

  int tests = 0;
  int fails = 0;

  in_t  pend[$];
  out_t sb[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  fpu_mul_norm_round dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp_sum(i_exp_sum), .i_mant_prod(i_mant_prod),
    .i_is_nan(i_is_nan), .i_is_inf(i_is_inf), .i_is_zero(i_is_zero),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_overflow(o_overflow), .o_underflow(o_underflow), .o_inexact(o_inexact)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact value is prod * 2^(es-127-46); round that to the FP32 grid.
  function automatic out_t model(input in_t b);
    out_t o;
    int es, eu, k, biased;
    logic tiny;
    longint unsigned p, r, rem, half;
    o = '0;
    if (b.nan)  begin o.res = 32'h7FC00000; return o; end
    if (b.inf)  begin o.res = {b.sign, 8'hFF, 23'd0}; return o; end
    if (b.zero) begin o.res = {b.sign, 31'd0}; return o; end
    es   = $signed(b.es);
    p    = {16'd0, b.prod};
    eu   = es - 127 + (b.prod[47] ? 1 : 0);
    tiny = (eu < -126);
    k    = ((tiny ? -126 : eu) - 23) - (es - 127 - 46);
    if (k > 60) k = 60;
    r    = p >> k;
    rem  = p & ((64'd1 << k) - 64'd1);
    half = 64'd1 << (k - 1);
    if (rem > half || (rem == half && r[0])) r = r + 64'd1;
    o.ix = (rem != 0);
    if (tiny) begin
      o.res = {b.sign, r[30:0]};
      o.un  = o.ix;
    end else begin
      if (r == (64'd1 << 24)) begin
        r  = 64'd1 << 23;
        eu = eu + 1;
      end
      biased = eu + 127;
      if (biased >= 255) begin
        o.res = {b.sign, 8'hFF, 23'd0};
        o.ov  = 1'b1;
        o.ix  = 1'b1;
      end else begin
        o.res = {b.sign, biased[7:0], r[22:0]};
      end
    end
    return o;
  endfunction

  function automatic in_t rand_in();
    in_t b;
    int sel;
    logic [63:0] w;
    b = '0;
    b.sign = 1'($urandom_range(1));
    sel = $urandom_range(99);
    if (sel < 40)      b.es = 10'($signed($urandom_range(60)) - 50);
    else if (sel < 70) b.es = 10'($urandom_range(160, 100));
    else if (sel < 90) b.es = 10'($urandom_range(300, 240));
    else               b.es = 10'($urandom);
    w = {$urandom, $urandom};
    if ($urandom_range(1) == 1) b.prod = {1'b1, w[46:0]};
    else                        b.prod = {2'b01, w[45:0]};
    if ($urandom_range(4) == 0) b.prod[23:0] = {1'b1, 23'd0};
    b.nan  = ($urandom_range(19) == 0);
    b.inf  = ($urandom_range(19) == 0);
    b.zero = ($urandom_range(19) == 0);
    return b;
  endfunction

  task automatic drive(input in_t b);
    i_sign = b.sign; i_exp_sum = b.es; i_mant_prod = b.prod;
    i_is_nan = b.nan; i_is_inf = b.inf; i_is_zero = b.zero;
  endtask

  // mode 0: random ready, mode 1: 3-cycle stall at cycles 3..5, mode 2: ready always high
  task automatic run_stream(input int mode, input int vpct, input int budget,
                            output int outs, output int cyc);
    in_t  cur;
    out_t ex;
    bit   acc;
    cur = '0; cyc = 0; outs = 0; i_valid = 1'b0;
    while ((pend.size() > 0 || i_valid || sb.size() > 0) && cyc < budget) begin
      if (!i_valid && pend.size() > 0 && $urandom_range(99) < vpct) begin
        cur = pend.pop_front();
        drive(cur);
        i_valid = 1'b1;
      end
      if (mode == 1)      i_ready = !(cyc >= 3 && cyc <= 5);
      else if (mode == 2) i_ready = 1'b1;
      else                i_ready = ($urandom_range(99) < 70);
      @(negedge clk);
      if (mode == 1 && cyc >= 3 && cyc <= 5) check("stall_o_ready", 64'(o_ready), 64'd0);
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'(o_valid), 64'd0);
        end else begin
          ex = sb.pop_front();
          check("stream_result", 64'(o_result), 64'(ex.res));
          check("stream_flags", 64'({o_overflow, o_underflow, o_inexact}), 64'({ex.ov, ex.un, ex.ix}));
          outs++;
        end
      end
      acc = i_valid && o_ready;
      if (acc) sb.push_back(model(cur));
      @(posedge clk);
      #1;
      if (acc) i_valid = 1'b0;
      cyc++;
    end
    if (cyc >= budget) begin
      tests++; fails++;
      $display("FAIL stream_timeout: got %0d cycles, limit %0d", cyc, budget);
      sb.delete(); pend.delete(); i_valid = 1'b0;
    end
  endtask

  initial begin
    int lat, outs, cyc, cnt;
    tbl[0]  = '{'{1'b0, 10'd127, 48'h900000000000, 1'b0, 1'b0, 1'b0}, '{32'h40100000, 1'b0, 1'b0, 1'b0}};
    tbl[1]  = '{'{1'b0, 10'd127, 48'h400000400000, 1'b0, 1'b0, 1'b0}, '{32'h3F800000, 1'b0, 1'b0, 1'b1}};
    tbl[2]  = '{'{1'b0, 10'd127, 48'h400000C00000, 1'b0, 1'b0, 1'b0}, '{32'h3F800002, 1'b0, 1'b0, 1'b1}};
    tbl[3]  = '{'{1'b0, 10'd254, 48'h800000000000, 1'b0, 1'b0, 1'b0}, '{32'h7F800000, 1'b1, 1'b0, 1'b1}};
    tbl[4]  = '{'{1'b1, 10'd254, 48'h800000000000, 1'b0, 1'b0, 1'b0}, '{32'hFF800000, 1'b1, 1'b0, 1'b1}};
    tbl[5]  = '{'{1'b0, 10'h3FF, 48'h400000000000, 1'b0, 1'b0, 1'b0}, '{32'h00200000, 1'b0, 1'b0, 1'b0}};
    tbl[6]  = '{'{1'b0, 10'h3C4, 48'h400000000000, 1'b0, 1'b0, 1'b0}, '{32'h00000000, 1'b0, 1'b1, 1'b1}};
    tbl[7]  = '{'{1'b0, 10'd127, 48'h900000000000, 1'b1, 1'b1, 1'b0}, '{32'h7FC00000, 1'b0, 1'b0, 1'b0}};
    tbl[8]  = '{'{1'b1, 10'd127, 48'h900000000000, 1'b0, 1'b0, 1'b1}, '{32'h80000000, 1'b0, 1'b0, 1'b0}};
    tbl[9]  = '{'{1'b1, 10'd10,  48'h900000000000, 1'b0, 1'b1, 1'b1}, '{32'hFF800000, 1'b0, 1'b0, 1'b0}};
    tbl[10] = '{'{1'b0, 10'd0,   48'h7FFFFF800000, 1'b0, 1'b0, 1'b0}, '{32'h00800000, 1'b0, 1'b1, 1'b1}};
    tbl[11] = '{'{1'b0, 10'd127, 48'hFFFFFF800000, 1'b0, 1'b0, 1'b0}, '{32'h40800000, 1'b0, 1'b0, 1'b1}};
    tbl[12] = '{'{1'b0, 10'd253, 48'hFFFFFF800000, 1'b0, 1'b0, 1'b0}, '{32'h7F800000, 1'b1, 1'b0, 1'b1}};

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    drive('0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_o_result", 64'(o_result), 64'd0);
    check("reset_flags", 64'({o_overflow, o_underflow, o_inexact}), 64'd0);
    check("reset_o_ready", 64'(o_ready), 64'd1);

    // directed vectors, one beat at a time, with latency measurement
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].in);
      i_valid = 1'b1; i_ready = 1'b1;
      lat = 0;
      while (lat < 6) begin
        @(posedge clk); lat++;
        #1 i_valid = 1'b0;
        @(negedge clk);
        if (o_valid) break;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_result", i), 64'(o_result), 64'(tbl[i].out.res));
      check($sformatf("vec%0d_flags", i), 64'({o_overflow, o_underflow, o_inexact}),
            64'({tbl[i].out.ov, tbl[i].out.un, tbl[i].out.ix}));
    end
    @(posedge clk); #1;

    // six beats with a three-cycle downstream stall
    for (int i = 0; i < 6; i++) pend.push_back(rand_in());
    run_stream(1, 100, 200, outs, cyc);
    check("stall_out_count", 64'(outs), 64'd6);

    // full-rate streaming must produce one result per cycle
    for (int i = 0; i < 20; i++) pend.push_back(rand_in());
    run_stream(2, 100, 200, outs, cyc);
    check("throughput_cycles", 64'(cyc), 64'd22);

    // random valid/ready traffic
    for (int i = 0; i < 400; i++) pend.push_back(rand_in());
    run_stream(0, 70, 5000, outs, cyc);
    check("random_out_count", 64'(outs), 64'd400);

    // reset with two beats in flight
    i_ready = 1'b1;
    drive(tbl[0].in); i_valid = 1'b1;
    @(posedge clk); #1;
    drive(tbl[1].in);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("inflight_o_valid", 64'(o_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_o_valid", 64'(o_valid), 64'd0);
    check("rst_async_o_result", 64'(o_result), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_o_ready", 64'(o_ready), 64'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_valid) cnt++;
    end
    check("post_rst_no_emit", 64'(cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
